// File: rtl/vend_change_dispenser.sv
// Vend result dispenser: pulses item release, then pays change to the coin hopper
// one coin at a time (largest first) over valid/ready, faulting on a stalled hopper.
module vend_change_dispenser #(
  parameter int HOPPER_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_req,
  input  logic [3:0] change_amt,
  input  logic [1:0] item_number,
  output logic       item_release,
  output logic [1:0] item_sel,
  output logic       coin_valid,
  output logic [3:0] coin_code,
  input  logic       coin_ready,
  output logic [3:0] remaining,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_RELEASE, S_SELECT, S_OFFER, S_DONE, S_FAULT
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(HOPPER_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] rem_r, coin_r, coin_val, coin_pick;
  logic [1:0] item_r;
  logic [7:0] wait_cnt;

  // Largest denomination not exceeding what is still owed.
  always_comb begin
    coin_pick = 4'b0001;
    if (rem_r >= 4'd10)     coin_pick = 4'b1000;
    else if (rem_r >= 4'd5) coin_pick = 4'b0100;
    else if (rem_r >= 4'd2) coin_pick = 4'b0010;
  end

  always_comb begin
    case (coin_r)
      4'b0001: coin_val = 4'd1;
      4'b0010: coin_val = 4'd2;
      4'b0100: coin_val = 4'd5;
      4'b1000: coin_val = 4'd10;
      default: coin_val = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    item_release = 1'b0;
    coin_valid   = 1'b0;
    coin_code    = 4'b0000;
    busy         = 1'b0;
    done         = 1'b0;
    fault        = 1'b0;
    case (state)
      S_IDLE:    if (vend_req) state_nxt = S_RELEASE;
      S_RELEASE: begin
        item_release = 1'b1;
        busy         = 1'b1;
        state_nxt    = S_SELECT;
      end
      S_SELECT: begin
        busy      = 1'b1;
        state_nxt = (rem_r == 4'd0) ? S_DONE : S_OFFER;
      end
      S_OFFER: begin
        busy       = 1'b1;
        coin_valid = 1'b1;
        coin_code  = coin_r;
        // An accept on the last allowed cycle beats the timeout.
        if (coin_ready)               state_nxt = S_SELECT;
        else if (wait_cnt == TO_LAST) state_nxt = S_FAULT;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_FAULT: begin
        fault = 1'b1;
        if (vend_req) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r    <= 4'd0;
      item_r   <= 2'd0;
      coin_r   <= 4'd0;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        S_IDLE: if (vend_req) begin
          rem_r  <= change_amt;
          item_r <= item_number;
        end
        S_SELECT: if (rem_r != 4'd0) begin
          coin_r   <= coin_pick;
          wait_cnt <= 8'd0;
        end
        S_OFFER: begin
          if (coin_ready) rem_r    <= rem_r - coin_val;
          else            wait_cnt <= wait_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign remaining = rem_r;
  assign item_sel  = item_r;

endmodule

// File: doc/vend_change_dispenser.md
# vend_change_dispenser

Change and item dispenser for the vending machine. It accepts one vend result (change amount in money units, item number) from the vending controller. It pulses the item release, then pays the change as a sequence of one-hot coin codes to the coin hopper over a valid/ready handshake, largest denomination first. It sits between the vending controller's money/item outputs and the physical hopper. A stalled hopper raises a fault.

## Interface
- HOPPER_TIMEOUT, 15: maximum cycles one coin is offered without `coin_ready` before fault; legal 1..255.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- vend_req  in  1  request; sampled only in IDLE (or FAULT for clearing).
- change_amt  in  4  change owed, 0..15 units; latched with accepted `vend_req`.
- item_number  in  2  item to release; latched with accepted `vend_req`.
- item_release  out  1  one-cycle item release pulse.
- item_sel  out  2  latched item number; valid while busy.
- coin_valid  out  1  coin offered to hopper.
- coin_code  out  4  one-hot denomination: 0001=1, 0010=2, 0100=5, 1000=10 units; 0000 when not offering.
- coin_ready  in  1  hopper accepts the offered coin.
- remaining  out  4  change still owed.
- busy  out  1  transaction in progress (RELEASE, SELECT, OFFER, DONE).
- done  out  1  one-cycle completion pulse.
- fault  out  1  hopper timeout; held until cleared.

## Operation
- States: IDLE, RELEASE, SELECT, OFFER, DONE, FAULT. All outputs are registered or decoded from state/registers; no combinational path from input to output.
- IDLE:
  - On `vend_req`=1, latch `change_amt` into `remaining` and `item_number` into `item_sel`, then go to RELEASE.
- RELEASE:
  - `item_release`=1 for this single cycle, then go to SELECT.
- SELECT:
  - If `remaining`=0, go to DONE.
  - Otherwise load the coin register with the largest denomination ≤ `remaining` (10, then 5, 2, 1), clear the wait counter, and go to OFFER.
  - `coin_valid`=0 in this state.
- OFFER:
  - `coin_valid`=1; `coin_code` stays stable until accepted.
  - Edge with `coin_ready`=1: `remaining` -= coin value, go to SELECT.
  - Edge with `coin_ready`=0: wait counter +1. If the counter was already HOPPER_TIMEOUT-1, go to FAULT instead.
  - `coin_ready` wins on the final cycle.
- DONE:
  - `done`=1 for one cycle, then go to IDLE.
- FAULT:
  - `fault`=1, `coin_valid`=0, `coin_code`=0, `busy`=0.
  - `remaining` and `item_sel` are frozen, for diagnosis.
  - `vend_req`=1 clears the fault and returns to IDLE; that request is not accepted as a transaction.
- Arithmetic: `remaining` is 4-bit unsigned. Subtraction never underflows because the denomination is chosen ≤ `remaining`.
- `vend_req` while busy: ignored; no queueing.
- `coin_ready` outside OFFER: ignored.

## Timing
- Reset (asynchronous assert, effective immediately) forces:
  - state = IDLE;
  - `remaining`=0, `item_sel`=0, `coin_code`=0;
  - `item_release`=0, `coin_valid`=0, `busy`=0, `done`=0, `fault`=0;
  - wait counter = 0.
- Reset mid-transaction abandons it; no further coins are offered.
- Cycle numbering: edge 0 samples `vend_req`.
  - Cycle 1: RELEASE (`item_release`, `busy`).
  - Cycle 2: SELECT.
  - Cycle 3: first OFFER.
- With `coin_ready` tied high, each coin costs 2 cycles (SELECT + OFFER).
  - `done` appears in cycle 3 + 2·(coin count).
  - For a zero-change vend, `done` appears in cycle 3.
- Earliest next accepted `vend_req`: the edge that ends the first IDLE cycle after DONE.
- Timeout: `coin_valid` stays high for at most HOPPER_TIMEOUT cycles per coin. FAULT is entered on the edge ending the HOPPER_TIMEOUT-th unready cycle.

## Test plan
- Reset state:
  - Stimulus: assert `rst` mid-OFFER, asynchronous to `clk`.
  - Response: all outputs drop to 0 immediately, without waiting for an edge; state is IDLE after release.
- Change 8, item 2, `coin_ready`=1:
  - `item_release` in cycle 1 with `item_sel`=2.
  - Coins 0100, 0010, 0001 in cycles 3, 5, 7.
  - `remaining` sequence 8→3→1→0.
  - `done` in cycle 9.
- Change 15:
  - Coins 1000, 0100 in that order; `done` in cycle 7.
- Change 0:
  - No `coin_valid`; `done` in cycle 3.
- Hopper backpressure, change 3:
  - Stimulus: `coin_ready` low for 4 cycles per coin, then high.
  - Response: `coin_code` stable through each stall; coins 0010, 0001; `done` follows; `fault` stays 0.
- Timeout and interference:
  - Stimulus: HOPPER_TIMEOUT=15, `coin_ready` held 0.
  - Response: `coin_valid` high exactly 15 cycles, then `fault`=1 with `remaining` frozen.
  - Stimulus: pulse `vend_req`.
  - Response: `fault`=0, IDLE, no release.
  - Stimulus: `vend_req` during OFFER.
  - Response: ignored.
